// File: rtl/paddle_input.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : paddle_input
//  Description : Player input front-end for a two-player bat-and-ball game.
//                Synchronises and debounces five raw buttons, turns the
//                debounced up/down buttons into clamped paddle-centre
//                positions updated on a slow movement tick, and converts the
//                serve button into a single-cycle serve pulse.
//  Ports       : clk        - system clock, all state updates on rising edge
//                rst_n      - asynchronous active-low reset
//                p1_up/p1_down, p2_up/p2_down - raw player buttons (async)
//                serve_btn  - raw serve button (async)
//                bat_size   - 0 = large paddle (half 29), 1 = small (half 19)
//                p1_y, p2_y - registered paddle centre y (11 bit)
//                serve      - one-cycle serve trigger
//  Parameters  : DB_COUNT   - stable cycles needed to accept an input change
//                MOVE_DIV   - clock cycles per paddle movement tick
//  Build macro : PADDLE_ACCEL_EN - adds per-paddle hold counters; the step
//                doubles to 2 pixels after 8 consecutive moving ticks.
//  Revision    : 1.0 - initial release
// ============================================================================
module paddle_input #(
    parameter logic [15:0] DB_COUNT = 16'd50000,
    parameter logic [15:0] MOVE_DIV = 16'd40000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        p1_up,
    input  logic        p1_down,
    input  logic        p2_up,
    input  logic        p2_down,
    input  logic        serve_btn,
    input  logic        bat_size,
    output logic [10:0] p1_y,
    output logic [10:0] p2_y,
    output logic        serve
);

    // Input channel order: 0 p1_up, 1 p1_down, 2 p2_up, 3 p2_down, 4 serve.
    localparam int          c_NUM_IN   = 5;
    localparam int          c_SERVE    = 4;
    localparam logic [15:0] c_DB_LAST  = DB_COUNT - 16'd1;
    localparam logic [15:0] c_DIV_LAST = MOVE_DIV - 16'd1;
    localparam logic [10:0] c_Y_RESET  = 11'd240;

    logic [c_NUM_IN-1:0] w_raw;
    logic [c_NUM_IN-1:0] r_sync1;
    logic [c_NUM_IN-1:0] r_sync2;
    logic [c_NUM_IN-1:0] w_db;
    logic [c_NUM_IN-1:0] w_db_flip;

    logic [15:0]         r_presc;
    logic                w_tick;

    logic [10:0]         w_half;
    logic [10:0]         w_ymin;
    logic [10:0]         w_ymax;

    logic                r_serve;
    logic [10:0]         w_y [2];

    assign w_raw = {serve_btn, p2_down, p2_up, p1_down, p1_up};

    // ------------------------------------------------------------------
    // Two-flop synchronisers for every raw input.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    // ------------------------------------------------------------------
    // Debouncers: the counter only advances while the synchronised value
    // disagrees with the accepted one, so any agreement restarts the wait.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < c_NUM_IN; gi++) begin : g_debounce
            logic [15:0] r_cnt;
            logic        r_db;
            logic        w_differ;

            assign w_differ      = (r_sync2[gi] != r_db);
            assign w_db_flip[gi] = w_differ && (r_cnt == c_DB_LAST);
            assign w_db[gi]      = r_db;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt <= 16'd0;
                    r_db  <= 1'b0;
                end else if (!w_differ) begin
                    r_cnt <= 16'd0;
                end else if (r_cnt == c_DB_LAST) begin
                    r_db  <= r_sync2[gi];
                    r_cnt <= 16'd0;
                end else begin
                    r_cnt <= r_cnt + 16'd1;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Serve pulse: registered on the same edge the debounced serve value
    // goes high, so it is exactly one cycle wide per accepted press.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_serve <= 1'b0;
        end else begin
            r_serve <= w_db_flip[c_SERVE] & r_sync2[c_SERVE];
        end
    end

    assign serve = r_serve;

    // ------------------------------------------------------------------
    // Movement prescaler.
    // ------------------------------------------------------------------
    assign w_tick = (r_presc == c_DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= 16'd0;
        end else if (w_tick) begin
            r_presc <= 16'd0;
        end else begin
            r_presc <= r_presc + 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // Vertical bounds depend on the current paddle size.
    // ------------------------------------------------------------------
    assign w_half = bat_size ? 11'd19 : 11'd29;
    assign w_ymin = 11'd31 + w_half;
    assign w_ymax = 11'd449 - w_half;

    // ------------------------------------------------------------------
    // Paddle position for each player.
    // ------------------------------------------------------------------
    genvar gp;
    generate
        for (gp = 0; gp < 2; gp++) begin : g_paddle
            logic               w_up;
            logic               w_down;
            logic               w_move_up;
            logic               w_move_dn;
            logic signed [11:0] w_step;
            logic signed [11:0] w_delta;
            logic signed [11:0] w_sum;
            logic        [10:0] w_clamp;
            logic        [10:0] r_y;

            assign w_up      = w_db[2*gp];
            assign w_down    = w_db[2*gp+1];
            // Both buttons together cancel out.
            assign w_move_up = w_up & ~w_down;
            assign w_move_dn = w_down & ~w_up;

`ifdef PADDLE_ACCEL_EN
            logic [3:0] r_hold;
            logic       r_dir_down;

            assign w_step = (r_hold >= 4'd8) ? 12'sd2 : 12'sd1;

            // Hold count tracks consecutive moving ticks in one direction;
            // an idle tick or a reversal restarts it.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_hold     <= 4'd0;
                    r_dir_down <= 1'b0;
                end else if (w_tick) begin
                    if (!(w_move_up | w_move_dn)) begin
                        r_hold <= 4'd0;
                    end else if ((r_hold != 4'd0) && (r_dir_down != w_move_dn)) begin
                        r_hold <= 4'd0;
                    end else if (r_hold != 4'd15) begin
                        r_hold <= r_hold + 4'd1;
                    end
                    if (w_move_up | w_move_dn) begin
                        r_dir_down <= w_move_dn;
                    end
                end
            end
`else
            assign w_step = 12'sd1;
`endif

            assign w_delta = (w_tick && w_move_up) ? -w_step :
                             (w_tick && w_move_dn) ?  w_step : 12'sd0;

            // 12-bit signed sum keeps an excursion past either edge visible
            // to the clamp instead of wrapping.
            assign w_sum = $signed({1'b0, r_y}) + w_delta;

            // The clamp runs every cycle so a size change pulls the paddle
            // inside the new bounds without waiting for a tick.
            assign w_clamp = (w_sum < $signed({1'b0, w_ymin})) ? w_ymin :
                             (w_sum > $signed({1'b0, w_ymax})) ? w_ymax :
                             w_sum[10:0];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_y <= c_Y_RESET;
                end else begin
                    r_y <= w_clamp;
                end
            end

            assign w_y[gp] = r_y;
        end
    endgenerate

    assign p1_y = w_y[0];
    assign p2_y = w_y[1];

endmodule
`default_nettype wire

// File: tb/tb_paddle_input.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_paddle_input
//  Description : Directed self-checking bench for paddle_input with
//                DB_COUNT=4 and MOVE_DIV=8. Expected positions are derived
//                from a cycle count since reset release: movement edges fall
//                on multiples of 8, and a press made just after such an edge
//                is accepted 6 edges later.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_paddle_input;

`ifdef PADDLE_ACCEL_EN
    localparam bit ACCEL = 1'b1;
`else
    localparam bit ACCEL = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        p1_up;
    logic        p1_down;
    logic        p2_up;
    logic        p2_down;
    logic        serve_btn;
    logic        bat_size;
    logic [10:0] p1_y;
    logic [10:0] p2_y;
    logic        serve;

    int n_checks;
    int n_fail;
    int cyc;
    int base;

    paddle_input #(
        .DB_COUNT (16'd4),
        .MOVE_DIV (16'd8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .p1_up     (p1_up),
        .p1_down   (p1_down),
        .p2_up     (p2_up),
        .p2_down   (p2_down),
        .serve_btn (serve_btn),
        .bat_size  (bat_size),
        .p1_y      (p1_y),
        .p2_y      (p2_y),
        .serve     (serve)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising edges seen since reset was released.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic align8();
        while ((cyc % 8) != 0) @(negedge clk);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        p1_up     = 1'b0;
        p1_down   = 1'b0;
        p2_up     = 1'b0;
        p2_down   = 1'b0;
        serve_btn = 1'b0;
        bat_size  = 1'b0;

        // Reset values.
        repeat (3) @(negedge clk);
        chk("reset_p1_y", 32'(p1_y), 32'd240);
        chk("reset_p2_y", 32'(p2_y), 32'd240);
        chk("reset_serve", 32'(serve), 32'd0);

        // Idle after release.
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("idle_state", {9'd0, p1_y, p2_y, serve}, {9'd0, 11'd240, 11'd240, 1'b0});
        end

        // A 3-cycle glitch must be rejected.
        p1_up = 1'b1;
        repeat (3) @(negedge clk);
        p1_up = 1'b0;
        repeat (40) @(negedge clk);
        chk("glitch_p1_y", 32'(p1_y), 32'd240);

        // p1_up held: one pixel per tick, stops at 60.
        align8();
        base  = cyc;
        p1_up = 1'b1;
        wait_until(base + 7);
        chk("p1_up_before_tick", 32'(p1_y), 32'd240);
        wait_until(base + 8);
        chk("p1_up_tick1", 32'(p1_y), 32'd239);
        wait_until(base + 16);
        chk("p1_up_tick2", 32'(p1_y), 32'd238);
        if (!ACCEL) begin
            wait_until(base + 1439);
            chk("p1_up_near_min", 32'(p1_y), 32'd61);
        end
        wait_until(base + 1440);
        chk("p1_up_at_min", 32'(p1_y), 32'd60);
        wait_until(base + 1480);
        chk("p1_up_hold_min", 32'(p1_y), 32'd60);
        p1_up = 1'b0;

        // Small paddle: p2 saturates at 430, then large size clamps to 420.
        bat_size = 1'b1;
        base     = cyc;
        p2_down  = 1'b1;
        if (!ACCEL) begin
            wait_until(base + 1519);
            chk("p2_down_near_max", 32'(p2_y), 32'd429);
        end
        wait_until(base + 1560);
        chk("p2_down_at_max", 32'(p2_y), 32'd430);
        bat_size = 1'b0;
        wait_until(base + 1561);
        chk("bat_size_clamp_p2", 32'(p2_y), 32'd420);
        chk("bat_size_keep_p1", 32'(p1_y), 32'd60);
        wait_until(base + 1600);
        chk("p2_hold_large_max", 32'(p2_y), 32'd420);
        p2_down = 1'b0;

        // p1 moves down 5 ticks, then both p1 buttons freeze it while p2
        // moves up in parallel.
        base    = cyc;
        p1_down = 1'b1;
        wait_until(base + 40);
        chk("p1_down_5ticks", 32'(p1_y), 32'd65);
        chk("p2_idle", 32'(p2_y), 32'd420);
        p1_up = 1'b1;
        p2_up = 1'b1;
        wait_until(base + 48);
        chk("both_p1_frozen", 32'(p1_y), 32'd65);
        chk("p2_up_tick1", 32'(p2_y), 32'd419);
        wait_until(base + 120);
        chk("both_p1_10ticks", 32'(p1_y), 32'd65);
        chk("p2_up_10ticks", 32'(p2_y), ACCEL ? 32'd408 : 32'd410);
        p1_up   = 1'b0;
        p1_down = 1'b0;
        p2_up   = 1'b0;
        wait_until(base + 160);
        chk("release_p1", 32'(p1_y), 32'd65);
        chk("release_p2", 32'(p2_y), ACCEL ? 32'd408 : 32'd410);

        // Serve: one pulse, 6 edges after the press, none on hold or release.
        serve_btn = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            chk($sformatf("serve_hold_%0d", k), 32'(serve), (k == 6) ? 32'd1 : 32'd0);
        end
        serve_btn = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            chk("serve_release", 32'(serve), 32'd0);
        end

        // Asynchronous reset in the middle of movement/debounce.
        p1_down = 1'b1;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_p1_y", 32'(p1_y), 32'd240);
        chk("async_rst_p2_y", 32'(p2_y), 32'd240);
        chk("async_rst_serve", 32'(serve), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // p1_down still held: first move lands MOVE_DIV edges after release.
        wait_until(7);
        chk("first_tick_before", 32'(p1_y), 32'd240);
        wait_until(8);
        chk("first_tick", 32'(p1_y), 32'd241);
        wait_until(64);
        chk("hold_8_ticks", 32'(p1_y), 32'd248);
        wait_until(72);
        chk("hold_9_ticks", 32'(p1_y), ACCEL ? 32'd250 : 32'd249);
        wait_until(80);
        chk("hold_10_ticks", 32'(p1_y), ACCEL ? 32'd252 : 32'd250);
        p1_down = 1'b0;
        wait_until(88);
        chk("released_still", 32'(p1_y), ACCEL ? 32'd252 : 32'd250);
        p1_down = 1'b1;
        wait_until(96);
        chk("repress_step1", 32'(p1_y), ACCEL ? 32'd253 : 32'd251);
        wait_until(104);
        chk("repress_step1_b", 32'(p1_y), ACCEL ? 32'd254 : 32'd252);
        p1_down = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/paddle_input.md
PADDLE_INPUT -- requirements
Module: paddle_input

Interface
REQ-001 Parameter DB_COUNT, default 16'd50000: consecutive stable cycles required for a debounced input change.
REQ-002 Parameter MOVE_DIV, default 16'd40000: clock cycles per paddle movement tick.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 p1_up, p1_down  input  1 each  raw player-1 buttons, asynchronous to clk.
REQ-006 p2_up, p2_down  input  1 each  raw player-2 buttons, asynchronous to clk.
REQ-007 serve_btn  input  1  raw serve button.
REQ-008 bat_size  input  1  0 = large paddle (half-height 29), 1 = small paddle (half-height 19).
REQ-009 p1_y, p2_y  output  11  paddle centre y, registered; feeds the game controller's p1_in/p2_in.
REQ-010 serve  output  1  one-cycle serve trigger pulse.

Function
REQ-011 Each of the five raw inputs SHALL pass through a two-flop synchroniser before any other use.
REQ-012 Each synchronised input SHALL have its own debouncer: 16-bit counter cleared whenever the synchronised value equals the debounced value, incremented otherwise; the debounced value SHALL take the synchronised value, and the counter SHALL clear, on the cycle the counter reaches DB_COUNT-1.
REQ-013 A synchronised pulse shorter than DB_COUNT cycles SHALL NOT change the debounced value.
REQ-014 A free-running 16-bit prescaler SHALL count 0..MOVE_DIV-1 and wrap to 0; tick SHALL be high for the single cycle in which the count equals MOVE_DIV-1.
REQ-015 On tick, a paddle with only debounced up asserted SHALL move by -step; only down asserted, +step; both or neither asserted, no move.
REQ-016 step SHALL be 1 pixel, except as modified by REQ-027.
REQ-017 Vertical bounds SHALL be y_min = 31 + half and y_max = 449 - half, where half = 29 (bat_size=0) or 19 (bat_size=1); i.e. 60..420 or 50..430.
REQ-018 Position arithmetic SHALL use 12-bit signed intermediates so that no 11-bit wrap-around occurs; the result SHALL be clamped to [y_min, y_max].
REQ-019 On every cycle, tick or not, a stored position outside the current bounds SHALL be clamped on the next edge, so a bat_size change takes effect within one cycle.
REQ-020 serve SHALL pulse high for exactly one cycle on the rising edge of debounced serve_btn; holding the button SHALL produce no further pulses.
REQ-021 Players 1 and 2 SHALL be fully independent; simultaneous activity on both SHALL move both on the same tick.

Reset
REQ-022 While rst_n = 0: p1_y = p2_y = 11'd240, serve = 0, prescaler = 0, all synchroniser flops, debounced values and debounce counters = 0, hold counters = 0.
REQ-023 Reset asserted mid-movement or mid-debounce SHALL abandon all pending state immediately (asynchronously).
REQ-024 After rst_n rises, the first tick SHALL occur MOVE_DIV cycles later.

Configuration
REQ-025 Macro PADDLE_ACCEL_EN selects paddle acceleration.
REQ-026 Without PADDLE_ACCEL_EN: step is always 1; no hold counters are implemented.
REQ-027 With PADDLE_ACCEL_EN: each paddle has a 4-bit hold counter, incremented on every tick in which the paddle moves and saturating at 15. It is cleared on any tick with no move, or with a direction reversal. step = 2 while the counter is >= 8. The clamp of REQ-018 still applies.

Verification (DB_COUNT=4, MOVE_DIV=8 unless stated)
REQ-028 Reset release, no buttons -> p1_y = p2_y = 240 and serve = 0 for 100 cycles.
REQ-029 p1_up held 3 synchronised cycles then released -> p1_y stays 240. p1_up held continuously -> p1_y decrements by 1 per tick and stops at 60 (bat_size=0).
REQ-030 p2_down held with bat_size=1 -> p2_y saturates at 430. Then set bat_size=0 -> p2_y = 420 within one cycle.
REQ-031 p1_up and p1_down both held -> p1_y unchanged across 10 ticks; p2 buttons simultaneously moving p2 as normal.
REQ-032 serve_btn held 50 cycles -> exactly one single-cycle serve pulse, occurring 2+4 cycles after the press.
REQ-033 PADDLE_ACCEL_EN defined, p1_down held from 240 -> 8 ticks of +1 (reaching 248), then +2 per tick; release then press -> step returns to 1. Reset asserted mid-hold -> p1_y = 240 immediately.
